// File: rtl/game_pkg.sv
// Shared definitions for the frame scheduler: sequencer states and camera origin.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    STREAM     = 3'd2,
    COLLECT    = 3'd3,
    WAIT_BLANK = 3'd4,
    COMMIT     = 3'd5
  } sched_state_e;

  // Camera position after reset (centre of the starting view).
  localparam int CAM_ORIGIN_X = 640;
  localparam int CAM_ORIGIN_Y = 360;

endpackage

// File: rtl/frame_scheduler_if.sv
// Handshake and camera bus between the video/game side and the frame scheduler.
interface frame_scheduler_if #(
  parameter int WORLD_BITS = 18
);

  logic                         new_frame_in;
  logic                         active_draw_in;
  logic [3:0]                   btn_in;
  logic                         env_done_in;
  logic                         obs_done_in;
  logic                         env_start_out;
  logic signed [WORLD_BITS-1:0] cam_next_x_out;
  logic signed [WORLD_BITS-1:0] cam_next_y_out;
  logic signed [WORLD_BITS-1:0] cam_x_out;
  logic signed [WORLD_BITS-1:0] cam_y_out;
  logic                         commit_out;
  logic                         busy_out;
  logic [7:0]                   overrun_count_out;

  // Driver side: video timing, buttons and the streamer/collector status.
  modport master (
    output new_frame_in, active_draw_in, btn_in, env_done_in, obs_done_in,
    input  env_start_out, cam_next_x_out, cam_next_y_out, cam_x_out, cam_y_out,
    input  commit_out, busy_out, overrun_count_out
  );

  // Scheduler side.
  modport slave (
    input  new_frame_in, active_draw_in, btn_in, env_done_in, obs_done_in,
    output env_start_out, cam_next_x_out, cam_next_y_out, cam_x_out, cam_y_out,
    output commit_out, busy_out, overrun_count_out
  );

endinterface

// File: rtl/camera_step.sv
// Combinational camera move: one axis per frame, button priority left > right > down > up,
// result clamped to [CAM_MIN, CAM_MAX] using one guard bit so nothing wraps.
module camera_step #(
  parameter int WORLD_BITS = 18,
  parameter int CAM_STEP   = 5,
  parameter int CAM_MIN    = -20000,
  parameter int CAM_MAX    = 20000
) (
  input  logic signed [WORLD_BITS-1:0] cur_x,
  input  logic signed [WORLD_BITS-1:0] cur_y,
  input  logic [3:0]                   btn,
  output logic signed [WORLD_BITS-1:0] next_x,
  output logic signed [WORLD_BITS-1:0] next_y
);

  localparam logic signed [WORLD_BITS:0] STEP_E = (WORLD_BITS+1)'(CAM_STEP);
  localparam logic signed [WORLD_BITS:0] MIN_E  = (WORLD_BITS+1)'(CAM_MIN);
  localparam logic signed [WORLD_BITS:0] MAX_E  = (WORLD_BITS+1)'(CAM_MAX);

  logic signed [WORLD_BITS:0] x_ext_s;
  logic signed [WORLD_BITS:0] y_ext_s;
  logic signed [WORLD_BITS:0] x_sum_s;
  logic signed [WORLD_BITS:0] y_sum_s;

  function automatic logic signed [WORLD_BITS-1:0] clamp(input logic signed [WORLD_BITS:0] v);
    logic signed [WORLD_BITS:0] c;
    if (v < MIN_E) begin
      c = MIN_E;
    end else if (v > MAX_E) begin
      c = MAX_E;
    end else begin
      c = v;
    end
    return c[WORLD_BITS-1:0];
  endfunction

  // Widen, apply the highest-priority pressed button, then clamp back to world width.
  always_comb begin
    x_ext_s = {cur_x[WORLD_BITS-1], cur_x};
    y_ext_s = {cur_y[WORLD_BITS-1], cur_y};
    x_sum_s = x_ext_s;
    y_sum_s = y_ext_s;
    if (btn[3]) begin
      x_sum_s = x_ext_s - STEP_E;
    end else if (btn[2]) begin
      x_sum_s = x_ext_s + STEP_E;
    end else if (btn[1]) begin
      y_sum_s = y_ext_s - STEP_E;
    end else if (btn[0]) begin
      y_sum_s = y_ext_s + STEP_E;
    end else begin
      x_sum_s = x_ext_s;
      y_sum_s = y_ext_s;
    end
    next_x = clamp(x_sum_s);
    next_y = clamp(y_sum_s);
  end

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: starts the environment stream, waits for stream and obstacle
// collection, then commits the pending camera during blanking. A new frame arriving
// before the commit aborts the sequence and is counted as an overrun.
module frame_scheduler
  import game_pkg::*;
#(
  parameter int WORLD_BITS = 18,
  parameter int CAM_STEP   = 5,
  parameter int CAM_MIN    = -20000,
  parameter int CAM_MAX    = 20000
) (
  input logic clk_in,
  input logic rst_in,
  frame_scheduler_if.slave bus
);

  localparam logic signed [WORLD_BITS-1:0] ORIGIN_X = (WORLD_BITS)'(CAM_ORIGIN_X);
  localparam logic signed [WORLD_BITS-1:0] ORIGIN_Y = (WORLD_BITS)'(CAM_ORIGIN_Y);

  sched_state_e                 state_r;
  logic                         obs_seen_r;
  logic                         env_start_r;
  logic                         commit_r;
  logic                         busy_r;
  logic [7:0]                   overrun_r;
  logic signed [WORLD_BITS-1:0] cam_next_x_r;
  logic signed [WORLD_BITS-1:0] cam_next_y_r;
  logic signed [WORLD_BITS-1:0] cam_x_r;
  logic signed [WORLD_BITS-1:0] cam_y_r;
  logic signed [WORLD_BITS-1:0] step_x_s;
  logic signed [WORLD_BITS-1:0] step_y_s;

  camera_step #(
    .WORLD_BITS (WORLD_BITS),
    .CAM_STEP   (CAM_STEP),
    .CAM_MIN    (CAM_MIN),
    .CAM_MAX    (CAM_MAX)
  ) u_camera_step (
    .cur_x  (cam_next_x_r),
    .cur_y  (cam_next_y_r),
    .btn    (bus.btn_in),
    .next_x (step_x_s),
    .next_y (step_y_s)
  );

  // Sequencer state, camera registers, overrun counter and registered output pulses.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r      <= IDLE;
      obs_seen_r   <= 1'b0;
      env_start_r  <= 1'b0;
      commit_r     <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 8'd0;
      cam_next_x_r <= ORIGIN_X;
      cam_next_y_r <= ORIGIN_Y;
      cam_x_r      <= ORIGIN_X;
      cam_y_r      <= ORIGIN_Y;
    end else begin
      env_start_r <= 1'b0;
      commit_r    <= 1'b0;
      // obs_done may arrive before or with env_done, so it is remembered until the next start.
      if (state_r == START) begin
        obs_seen_r <= 1'b0;
      end else if (bus.obs_done_in) begin
        obs_seen_r <= 1'b1;
      end else begin
        obs_seen_r <= obs_seen_r;
      end
      if (bus.new_frame_in && (state_r != COMMIT)) begin
        // Fresh frame: normal start from IDLE, otherwise abandon the unfinished sequence.
        if ((state_r != IDLE) && (overrun_r != 8'd255)) begin
          overrun_r <= overrun_r + 8'd1;
        end else begin
          overrun_r <= overrun_r;
        end
        cam_next_x_r <= step_x_s;
        cam_next_y_r <= step_y_s;
        state_r      <= START;
        env_start_r  <= 1'b1;
        busy_r       <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
          START: begin
            state_r <= STREAM;
            busy_r  <= 1'b1;
          end
          STREAM: begin
            busy_r <= 1'b1;
            if (bus.env_done_in) begin
              state_r <= COLLECT;
            end else begin
              state_r <= STREAM;
            end
          end
          COLLECT: begin
            busy_r <= 1'b1;
            if (obs_seen_r || bus.obs_done_in) begin
              state_r <= WAIT_BLANK;
            end else begin
              state_r <= COLLECT;
            end
          end
          WAIT_BLANK: begin
            busy_r <= 1'b1;
            if (!bus.active_draw_in) begin
              state_r  <= COMMIT;
              commit_r <= 1'b1;
            end else begin
              state_r <= WAIT_BLANK;
            end
          end
          COMMIT: begin
            // The commit always completes with the camera that was culled against.
            cam_x_r <= cam_next_x_r;
            cam_y_r <= cam_next_y_r;
            if (bus.new_frame_in) begin
              cam_next_x_r <= step_x_s;
              cam_next_y_r <= step_y_s;
              state_r      <= START;
              env_start_r  <= 1'b1;
              busy_r       <= 1'b1;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.env_start_out     = env_start_r;
  assign bus.commit_out        = commit_r;
  assign bus.busy_out          = busy_r;
  assign bus.overrun_count_out = overrun_r;
  assign bus.cam_next_x_out    = cam_next_x_r;
  assign bus.cam_next_y_out    = cam_next_y_r;
  assign bus.cam_x_out         = cam_x_r;
  assign bus.cam_y_out         = cam_y_r;

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler: reset values, a button table, directed
// multi-cycle sequences and a randomized run against a frame-level reference model.
module tb_frame_scheduler;

  localparam int WB   = 18;
  localparam int STEP = 5;
  localparam int CMIN = -20000;
  localparam int CMAX = 20000;
  localparam int OX   = 640;
  localparam int OY   = 360;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  frame_scheduler_if #(.WORLD_BITS(WB)) bus ();

  frame_scheduler #(
    .WORLD_BITS (WB),
    .CAM_STEP   (STEP),
    .CAM_MIN    (CMIN),
    .CAM_MAX    (CMAX)
  ) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic clear_inputs();
    bus.new_frame_in   = 1'b0;
    bus.env_done_in    = 1'b0;
    bus.obs_done_in    = 1'b0;
    bus.active_draw_in = 1'b1;
    bus.btn_in         = 4'b0000;
  endtask

  // Leaves the bench 1 time unit after a rising edge with the DUT out of reset.
  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Applies per-cycle input masks (bit c = cycle c) and records per-cycle outputs.
  task automatic run_seq(input int ncyc, input logic [63:0] nf_m, input logic [63:0] env_m,
                         input logic [63:0] obs_m, input logic [63:0] ad_m,
                         input logic [3:0] b0, input logic [3:0] b1, input int bsw,
                         output logic [63:0] st_m, output logic [63:0] cm_m,
                         output logic [63:0] bz_m, output logic [63:0] cc_m);
    logic signed [WB-1:0] cam0;
    st_m = 64'd0; cm_m = 64'd0; bz_m = 64'd0; cc_m = 64'd0;
    cam0 = bus.cam_x_out;
    for (int c = 0; c < ncyc; c++) begin
      bus.new_frame_in   = nf_m[c];
      bus.env_done_in    = env_m[c];
      bus.obs_done_in    = obs_m[c];
      bus.active_draw_in = ad_m[c];
      bus.btn_in         = (c < bsw) ? b0 : b1;
      @(negedge clk);
      st_m[c] = bus.env_start_out;
      cm_m[c] = bus.commit_out;
      bz_m[c] = bus.busy_out;
      cc_m[c] = (bus.cam_x_out != cam0);
      @(posedge clk);
      #1;
    end
    clear_inputs();
  endtask

  // ---------------- reference model (frame-level phases, integer camera) ----------------
  bit m_busy, m_start, m_wenv, m_wobs, m_wblank, m_commit, m_obs;
  int m_nx, m_ny, m_cx, m_cy, m_ovr;

  function automatic int clampi(input int v);
    if (v < CMIN) return CMIN;
    if (v > CMAX) return CMAX;
    return v;
  endfunction

  task automatic m_reset();
    {m_busy, m_start, m_wenv, m_wobs, m_wblank, m_commit, m_obs} = 7'd0;
    m_nx = OX; m_ny = OY; m_cx = OX; m_cy = OY; m_ovr = 0;
  endtask

  task automatic m_move(input logic [3:0] b);
    if (b[3]) m_nx = clampi(m_nx - STEP);
    else if (b[2]) m_nx = clampi(m_nx + STEP);
    else if (b[1]) m_ny = clampi(m_ny - STEP);
    else if (b[0]) m_ny = clampi(m_ny + STEP);
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit obs_n, was_commit;
    obs_n      = m_start ? 1'b0 : (m_obs | bus.obs_done_in);
    was_commit = m_commit;
    if (was_commit) begin m_cx = m_nx; m_cy = m_ny; end
    if (bus.new_frame_in) begin
      if (m_busy && !was_commit && m_ovr < 255) m_ovr++;
      m_move(bus.btn_in);
      {m_start, m_wenv, m_wobs, m_wblank, m_commit} = 5'b10000;
      m_busy = 1'b1;
    end else if (m_start) begin
      m_start = 1'b0; m_wenv = 1'b1;
    end else if (m_wenv) begin
      if (bus.env_done_in) begin m_wenv = 1'b0; m_wobs = 1'b1; end
    end else if (m_wobs) begin
      if (m_obs || bus.obs_done_in) begin m_wobs = 1'b0; m_wblank = 1'b1; end
    end else if (m_wblank) begin
      if (!bus.active_draw_in) begin m_wblank = 1'b0; m_commit = 1'b1; end
    end else if (m_commit) begin
      m_commit = 1'b0; m_busy = 1'b0;
    end
    m_obs = obs_n;
  endtask

  typedef struct {
    logic [3:0] btn;
    int         dx;
    int         dy;
  } btn_vec_t;

  btn_vec_t vecs[8];

  initial begin
    logic [63:0] st_m, cm_m, bz_m, cc_m;
    logic        any_pulse;

    vecs[0] = '{4'b1100, -5,  0};
    vecs[1] = '{4'b0100,  5,  0};
    vecs[2] = '{4'b0010,  0, -5};
    vecs[3] = '{4'b0001,  0,  5};
    vecs[4] = '{4'b1111, -5,  0};
    vecs[5] = '{4'b0011,  0, -5};
    vecs[6] = '{4'b0000,  0,  0};
    vecs[7] = '{4'b0110,  5,  0};

    // Reset values
    do_reset();
    @(negedge clk);
    check("reset busy", bus.busy_out, 0);
    check("reset env_start", bus.env_start_out, 0);
    check("reset commit", bus.commit_out, 0);
    check("reset overrun", bus.overrun_count_out, 0);
    check("reset cam_x", bus.cam_x_out, OX);
    check("reset cam_y", bus.cam_y_out, OY);
    check("reset cam_next_x", bus.cam_next_x_out, OX);
    check("reset cam_next_y", bus.cam_next_y_out, OY);

    // Button priority table: one frame from reset each
    foreach (vecs[i]) begin
      do_reset();
      run_seq(3, 64'h1, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, vecs[i].btn, vecs[i].btn, 0,
              st_m, cm_m, bz_m, cc_m);
      check($sformatf("btn %b next_x", vecs[i].btn), bus.cam_next_x_out, OX + vecs[i].dx);
      check($sformatf("btn %b next_y", vecs[i].btn), bus.cam_next_y_out, OY + vecs[i].dy);
    end

    // Nominal frame
    do_reset();
    run_seq(26, 64'h1, 64'h400, 64'h1000, 64'hF_FFFF, 4'b0100, 4'b0100, 0, st_m, cm_m, bz_m, cc_m);
    check("nominal env_start cycles", st_m, 64'h2);
    check("nominal commit cycles", cm_m, 64'h20_0000);
    check("nominal busy cycles", bz_m, 64'h3F_FFFE);
    check("nominal cam change cycles", cc_m, 64'h3C0_0000);
    check("nominal cam_x after commit", bus.cam_x_out, OX + 5);

    // Overrun: env_done never arrives over three frames
    do_reset();
    run_seq(60, 64'h0000_0100_0010_0001, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, 4'b0000, 0,
            st_m, cm_m, bz_m, cc_m);
    check("overrun env_start cycles", st_m, 64'h0000_0200_0020_0002);
    check("overrun commit cycles", cm_m, 64'h0);
    check("overrun count", bus.overrun_count_out, 2);

    // Early obs_done in STREAM: COLLECT must exit in its first cycle
    do_reset();
    run_seq(20, 64'h1, 64'h400, 64'h100, 64'h0, 4'b0000, 4'b0000, 0, st_m, cm_m, bz_m, cc_m);
    check("early obs commit cycles", cm_m, 64'h2000);
    check("early obs busy cycles", bz_m, 64'h3FFE);

    // New frame arriving in COMMIT
    do_reset();
    run_seq(12, 64'h41, 64'h8, 64'h10, 64'h0, 4'b0100, 4'b0001, 6, st_m, cm_m, bz_m, cc_m);
    check("commit+frame commit cycles", cm_m, 64'h40);
    check("commit+frame env_start cycles", st_m, 64'h82);
    check("commit+frame overrun", bus.overrun_count_out, 0);
    check("commit+frame cam_x", bus.cam_x_out, OX + 5);
    check("commit+frame next_x", bus.cam_next_x_out, OX + 5);
    check("commit+frame next_y", bus.cam_next_y_out, OY + 5);

    // Reset asserted mid-sequence
    do_reset();
    run_seq(26, 64'h1, 64'h400, 64'h1000, 64'hF_FFFF, 4'b0100, 4'b0100, 0, st_m, cm_m, bz_m, cc_m);
    run_seq(8, 64'h5, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100, 4'b0100, 0, st_m, cm_m, bz_m, cc_m);
    check("pre-reset overrun", bus.overrun_count_out, 1);
    check("pre-reset next_x", bus.cam_next_x_out, OX + 15);
    check("pre-reset busy", bus.busy_out, 1);
    rst_n = 1'b0;
    #2;
    check("mid reset busy", bus.busy_out, 0);
    check("mid reset overrun", bus.overrun_count_out, 0);
    check("mid reset cam_x", bus.cam_x_out, OX);
    check("mid reset cam_y", bus.cam_y_out, OY);
    check("mid reset next_x", bus.cam_next_x_out, OX);
    check("mid reset next_y", bus.cam_next_y_out, OY);
    bus.new_frame_in = 1'b1;
    bus.env_done_in  = 1'b1;
    any_pulse = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      any_pulse = any_pulse | bus.env_start_out | bus.commit_out | bus.busy_out;
    end
    @(posedge clk);
    #1;
    clear_inputs();
    rst_n = 1'b1;
    check("in reset pulses", any_pulse, 0);
    run_seq(6, 64'h1, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, 4'b0000, 0, st_m, cm_m, bz_m, cc_m);
    check("after reset env_start cycles", st_m, 64'h2);

    // Clamping: new_frame every cycle moves cam_next by one step per edge
    do_reset();
    bus.new_frame_in = 1'b1;
    bus.btn_in       = 4'b0100;
    repeat (3871) @(posedge clk);
    #1;
    check("clamp approach x", bus.cam_next_x_out, 19995);
    @(posedge clk);
    #1;
    check("clamp reach max x", bus.cam_next_x_out, CMAX);
    repeat (5) @(posedge clk);
    #1;
    check("clamp hold max x", bus.cam_next_x_out, CMAX);
    check("overrun saturates", bus.overrun_count_out, 255);
    bus.btn_in = 4'b1000;
    repeat (8005) @(posedge clk);
    #1;
    check("clamp hold min x", bus.cam_next_x_out, CMIN);
    check("clamp y untouched", bus.cam_next_y_out, OY);
    clear_inputs();

    // Randomized run against the reference model
    do_reset();
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.new_frame_in   = ($urandom_range(0, 29) == 0);
      bus.env_done_in    = ($urandom_range(0, 5) == 0);
      bus.obs_done_in    = ($urandom_range(0, 7) == 0);
      bus.active_draw_in = ($urandom_range(0, 9) < 7);
      bus.btn_in         = 4'($urandom_range(0, 15));
      @(negedge clk);
      n_total++;
      if (bus.env_start_out == m_start && bus.commit_out == m_commit && bus.busy_out == m_busy &&
          bus.cam_x_out == m_cx && bus.cam_y_out == m_cy &&
          bus.cam_next_x_out == m_nx && bus.cam_next_y_out == m_ny &&
          bus.overrun_count_out == m_ovr) begin
        n_pass++;
      end else begin
        $display("FAIL random cycle %0d: start %0b/%0b commit %0b/%0b busy %0b/%0b cam %0d,%0d/%0d,%0d next %0d,%0d/%0d,%0d ovr %0d/%0d (got/expected)",
                 i, bus.env_start_out, m_start, bus.commit_out, m_commit, bus.busy_out, m_busy,
                 bus.cam_x_out, bus.cam_y_out, m_cx, m_cy,
                 bus.cam_next_x_out, bus.cam_next_y_out, m_nx, m_ny,
                 bus.overrun_count_out, m_ovr);
      end
      @(posedge clk);
      model_edge();
      #1;
    end
    clear_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 SHALL have parameter WORLD_BITS, default 18, meaning signed world-coordinate width.
REQ-002 SHALL have parameter CAM_STEP, default 5, meaning camera move per frame in world units.
REQ-003 SHALL have parameter CAM_MIN, default -20000, meaning lower camera coordinate clamp.
REQ-004 SHALL have parameter CAM_MAX, default 20000, meaning upper camera coordinate clamp.
REQ-005 SHALL have clk_in, input, 1, pixel clock; the design has one clock.
REQ-006 SHALL have rst_in, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have new_frame_in, input, 1, one-cycle new-frame strobe from the video signal generator.
REQ-008 SHALL have active_draw_in, input, 1, high inside the drawing region.
REQ-009 SHALL have btn_in, input, 4, camera buttons: [3] left, [2] right, [1] down, [0] up.
REQ-010 SHALL have env_done_in, input, 1, environment stream finished.
REQ-011 SHALL have obs_done_in, input, 1, on-screen obstacle collector finished.
REQ-012 SHALL have env_start_out, output, 1, one-cycle start pulse to the environment streamer.
REQ-013 SHALL have cam_next_x_out and cam_next_y_out, output, signed WORLD_BITS each, pending camera used for culling.
REQ-014 SHALL have cam_x_out and cam_y_out, output, signed WORLD_BITS each, committed camera used by render.
REQ-015 SHALL have commit_out, output, 1, one-cycle pulse that swaps render-side obstacle buffers.
REQ-016 SHALL have busy_out, output, 1, high whenever the state is not IDLE.
REQ-017 SHALL have overrun_count_out, output, 8, saturating count of aborted frames.

Function
REQ-018 SHALL use states IDLE, START, STREAM, COLLECT, WAIT_BLANK and COMMIT.
REQ-019 SHALL, on new_frame_in in IDLE, update cam_next per the button rule and go to START; both take effect on the next edge.
REQ-020 SHALL apply the button rule with priority btn[3] > btn[2] > btn[1] > btn[0]:
- btn[3]: x -= CAM_STEP
- btn[2]: x += CAM_STEP
- btn[1]: y -= CAM_STEP
- btn[0]: y += CAM_STEP
- only one axis moves per frame.
REQ-021 SHALL clamp the updated coordinate to [CAM_MIN, CAM_MAX] and use no wrap-around arithmetic.
REQ-022 SHALL drive env_start_out high for exactly the single cycle spent in START, then go to STREAM.
REQ-023 SHALL stay in STREAM until env_done_in is high, then go to COLLECT.
REQ-024 SHALL keep a sticky obs_seen flag, cleared in START and set by obs_done_in in any other state, so an early or coincident obs_done is not lost.
REQ-025 SHALL leave COLLECT for WAIT_BLANK in the cycle where obs_seen or obs_done_in is high.
REQ-026 SHALL stay in WAIT_BLANK while active_draw_in is high and go to COMMIT on the first cycle it is low.
REQ-027 SHALL, in COMMIT, drive commit_out high for one cycle and load cam_x/cam_y from cam_next on the same edge, then go to IDLE.
REQ-028 SHALL, on new_frame_in in START, STREAM, COLLECT or WAIT_BLANK:
- abort the sequence without a commit
- increment overrun_count_out, saturating at 255
- update cam_next
- go to START.
REQ-029 SHALL, on new_frame_in in COMMIT, still complete the commit using the old cam_next, without counting an overrun, then update cam_next and go to START.
REQ-030 SHALL ignore env_done_in outside STREAM.
REQ-031 SHALL hold cam_x/cam_y constant between commits, so render sees a stable camera for a whole frame.

Reset
REQ-032 SHALL, while rst_in is low, asynchronously force:
- state IDLE
- env_start_out, commit_out, busy_out and obs_seen to 0
- overrun_count_out to 0
- cam_next and cam_x/cam_y to (640, 360).
REQ-033 SHALL, when reset asserts mid-sequence, emit no start or commit pulse, and SHALL accept the first new_frame_in after deassertion normally.

Structure
REQ-034 SHALL put the state enum typedef and the default camera origin constants (640, 360) in a shared package game_pkg.
REQ-035 SHALL place the clamped camera step in sub-module camera_step, which is combinational: current x/y plus buttons in, clamped next x/y out.

Verification
REQ-036 SHALL cover the nominal frame:
- stimulus: new_frame at cycle 0; env_done at cycle 10; obs_done at cycle 12; active_draw low from cycle 20
- required: env_start high at cycle 1 only; commit high at cycle 21 only; cam_out unchanged before cycle 22.
REQ-037 SHALL cover buttons and clamping:
- btn=4'b1100 from reset, one frame: cam_next_x=635, cam_next_y=360
- btn[2] held with cam_next_x=19998: cam_next_x=20000 and stays 20000 on the next frame.
REQ-038 SHALL cover overrun: env_done never asserted over 3 new_frames -> overrun_count=2, env_start pulses 3 times, no commit_out.
REQ-039 SHALL cover early obs_done: obs_done in STREAM 2 cycles before env_done -> COLLECT exits in its first cycle.
REQ-040 SHALL cover reset mid-sequence: rst_in low in STREAM -> state IDLE, cam_out and cam_next (640, 360), counter 0, no pulses.
REQ-041 SHALL cover new_frame in COMMIT: commit_out pulses, overrun_count unchanged, env_start pulses on the following cycle.
